otter_alu: RTL and testbench
============================

Name: otter_alu

Overview:
- 32-bit integer ALU for the Otter RV32I core; executes the EX-stage arithmetic, logic, shift, compare and LUI pass-through operations.
- The result path is purely combinational.
- A registered copy of the result is also provided, with a valid flag, for pipelined/forwarding consumers.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; shift amount is always 5 bits.
- POISON, 32'hDEADDEAD, value driven for unsupported func codes.

Ports:
- clk  in  1  system clock; rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- src_a  in  32  operand A (rs1, PC, or U-immediate for LUI).
- src_b  in  32  operand B (rs2 or immediate).
- func  in  4  operation select.
- valid_in  in  1  qualifies src_a/src_b/func for capture into the register stage.
- result  out  32  combinational result.
- result_q  out  32  registered result.
- valid_q  out  1  registered valid_in.

Behaviour:
- Encodings (func -> operation):
  - 0000 ADD: a+b, mod 2^32, carry discarded.
  - 1000 SUB: a-b, mod 2^32.
  - 0110 OR.
  - 0111 AND.
  - 0100 XOR.
  - 0001 SLL: a << b[4:0].
  - 0101 SRL: logical a >> b[4:0].
  - 1101 SRA: arithmetic a >>> b[4:0], sign-filled from a[31].
  - 0010 SLT: {31'b0, signed(a) < signed(b)}.
  - 0011 SLTU: {31'b0, a < b}, unsigned.
  - 1001 LUI: result = src_a; src_b is ignored.
  - All other codes (1010, 1011, 1100, 1110, 1111): result = POISON.
- Shift rules:
  - b[31:5] is ignored, so a shift by 33 equals a shift by 1.
  - A shift by 0 returns a unchanged.
- result is a zero-latency combinational function of src_a/src_b/func only; it has no dependency on clk or rst_n and contains no latches.
- Register stage, on the rising edge of clk:
  - valid_q <= valid_in.
  - If valid_in = 1: result_q <= result.
  - If valid_in = 0: result_q holds its previous value.
- Reset:
  - rst_n low immediately (asynchronously) forces result_q = 32'h0 and valid_q = 0.
  - Deassertion takes effect at the next clock edge.
  - A reset asserted mid-operation discards any capture on that edge.
- X handling: no X is allowed to reach result for any defined func; illegal codes return POISON.

Optional Feature:
- Macro OTTER_ALU_FLAGS_EN.
- When defined, three extra outputs are added:
  - zero (1): result == 0.
  - illegal (1): func is an unused encoding.
  - zero_q (1): zero registered alongside result_q, with reset value 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package otter_pkg holds:
  - the 4-bit ALU func typedef/enum (ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SRL, ALU_SLL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI) with the encodings above;
  - XLEN;
  - the POISON constant.
- One natural sub-module: otter_alu_shifter. It is a single barrel shifter serving SLL/SRL/SRA (left via bit-reverse, with an arithmetic-fill select).

Test Plan:
- ADD/SUB:
  - 12345678+87654321 -> 99999999.
  - FFFFFFFF+1 -> 00000000.
  - 7FFFFFFF+1 -> 80000000.
  - SUB 12345678-87654321 -> 8ACF1357.
- Logic:
  - OR 0F0F0F0F|F0F0F0F0 -> FFFFFFFF.
  - AND of the same operands -> 00000000.
  - XOR 12345678^12345678 -> 00000000.
- Shifts:
  - SRL 80000000>>33 -> 40000000.
  - SLL 1<<31 -> 80000000.
  - SRA 80000000>>>1 -> C0000000.
  - SRA 80000000>>>31 -> FFFFFFFF.
  - SRA 40000000>>>1 -> 20000000.
- Compare:
  - SLT FFFFFFFF<1 -> 1; FFFFFFFE<FFFFFFFF -> 1; equal operands -> 0.
  - SLTU 7FFFFFFF<80000000 -> 1; reversed -> 0.
- LUI and illegal:
  - LUI with a=12345678, b=87654321 -> 12345678.
  - func=1111 -> DEADDEAD; with OTTER_ALU_FLAGS_EN, illegal=1.
- Registers:
  - With rst_n low: result_q=0 and valid_q=0 regardless of clk.
  - After release, valid_in=1 with ADD 2+3 -> result_q=5, valid_q=1 one edge later.
  - Then valid_in=0 with new operands -> result_q stays 5, valid_q=0.
  - Asserting rst_n low between edges clears result_q immediately.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared Otter definitions: datapath width, ALU func encodings and the poison value.
package otter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNC_W   = 4;
  localparam logic [XLEN-1:0] POISON = 32'hDEADDEAD;

  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_func_e;

  // True for the encodings the ALU implements; everything else returns POISON.
  function automatic logic alu_func_legal(input logic [FUNC_W-1:0] f);
    case (f)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_LUI, ALU_SRA: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_alu_shifter.sv
// Single right barrel shifter serving SLL/SRL/SRA; left shifts reuse it by bit-reversing
// the operand on the way in and the result on the way out.
module otter_alu_shifter
  import otter_pkg::*;
(
  input  logic [XLEN-1:0]    src,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               shift_left,
  input  logic               arith,
  output logic [XLEN-1:0]    shifted_c
);

  logic [XLEN-1:0]        src_rev;
  logic [XLEN-1:0]        operand;
  logic [XLEN-1:0]        right_res;
  logic [XLEN-1:0]        right_rev;
  logic signed [XLEN:0]   ext;
  logic signed [XLEN:0]   ext_shr;
  logic                   fill;

  always_comb begin
    src_rev = '0;
    for (int i = 0; i < int'(XLEN); i++) src_rev[i] = src[XLEN-1-i];
  end

  assign operand   = shift_left ? src_rev : src;
  // Sign fill only for arithmetic right shifts; left shifts always fill with zero.
  assign fill      = arith & ~shift_left & src[XLEN-1];
  assign ext       = {fill, operand};
  assign ext_shr   = ext >>> shamt;
  assign right_res = ext_shr[XLEN-1:0];

  always_comb begin
    right_rev = '0;
    for (int i = 0; i < int'(XLEN); i++) right_rev[i] = right_res[XLEN-1-i];
  end

  assign shifted_c = shift_left ? right_rev : right_res;

endmodule

// File: rtl/otter_alu.sv
// Otter RV32I EX-stage ALU: combinational result plus a registered copy with valid.
// Optional flag outputs (zero, illegal, zero_q) are enabled by defining OTTER_ALU_FLAGS_EN.
module otter_alu
  import otter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [FUNC_W-1:0] func,
  input  logic              valid_in,
  output logic [XLEN-1:0]   result,
  output logic [XLEN-1:0]   result_q,
  output logic              valid_q
`ifdef OTTER_ALU_FLAGS_EN
  ,
  output logic              zero,
  output logic              illegal,
  output logic              zero_q
`endif
);

  logic [XLEN-1:0] shift_res;
  logic            slt;
  logic            sltu;

  otter_alu_shifter u_shifter (
    .src        (src_a),
    .shamt      (src_b[SHAMT_W-1:0]),
    .shift_left (func == ALU_SLL),
    .arith      (func == ALU_SRA),
    .shifted_c  (shift_res)
  );

  assign slt  = $signed(src_a) < $signed(src_b);
  assign sltu = src_a < src_b;

  // Operation select; undefined encodings fall through to the poison value.
  always_comb begin
    result = POISON;
    case (func)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result = shift_res;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu};
      ALU_LUI:  result = src_a;
      default:  result = POISON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) result_q <= result;
    end
  end

`ifdef OTTER_ALU_FLAGS_EN
  assign zero    = (result == '0);
  assign illegal = ~alu_func_legal(func);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_q <= 1'b0;
    else if (valid_in) zero_q <= zero;
  end
`endif

endmodule

// File: tb/tb_otter_alu.sv
// Directed-vector self-checking bench for otter_alu (combinational ops and register stage).
module tb_otter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  func;
  logic        valid_in;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        valid_q;
`ifdef OTTER_ALU_FLAGS_EN
  logic        zero;
  logic        illegal;
  logic        zero_q;
`endif

  int checks = 0;
  int errors = 0;

  otter_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_a    (src_a),
    .src_b    (src_b),
    .func     (func),
    .valid_in (valid_in),
    .result   (result),
    .result_q (result_q),
    .valid_q  (valid_q)
`ifdef OTTER_ALU_FLAGS_EN
    ,
    .zero     (zero),
    .illegal  (illegal),
    .zero_q   (zero_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [3:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp);
    func  = f;
    src_a = a;
    src_b = b;
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    func     = 4'b0000;
    src_a    = '0;
    src_b    = '0;

    // Reset state, before and across clock edges
    #2;
    check("rst_result_q", result_q, 32'h0);
    check("rst_valid_q", {31'b0, valid_q}, 32'h0);
    valid_in = 1'b1;
    src_a = 32'h11; src_b = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_result_q", result_q, 32'h0);
    check("rst_hold_valid_q", {31'b0, valid_q}, 32'h0);
    valid_in = 1'b0;

    // ADD / SUB
    op("add_basic",  4'b0000, 32'h12345678, 32'h87654321, 32'h99999999);
    op("add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    op("add_ovf",    4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
    op("sub_basic",  4'b1000, 32'h12345678, 32'h87654321, 32'h8ACF1357);
    // Logic
    op("or",         4'b0110, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF);
    op("and",        4'b0111, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000);
    op("and_mixed",  4'b0111, 32'h12345678, 32'hFF00FF00, 32'h12005600);
    op("xor_self",   4'b0100, 32'h12345678, 32'h12345678, 32'h00000000);
    op("xor_mixed",  4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555);
    // Shifts
    op("srl_33",     4'b0101, 32'h80000000, 32'd33,       32'h40000000);
    op("srl_4",      4'b0101, 32'hF0000001, 32'd4,        32'h0F000000);
    op("sll_31",     4'b0001, 32'h00000001, 32'd31,       32'h80000000);
    op("sll_8",      4'b0001, 32'h12345678, 32'd8,        32'h34567800);
    op("sll_0",      4'b0001, 32'h12345678, 32'd0,        32'h12345678);
    op("sll_32",     4'b0001, 32'h12345678, 32'd32,       32'h12345678);
    op("sra_1",      4'b1101, 32'h80000000, 32'd1,        32'hC0000000);
    op("sra_31",     4'b1101, 32'h80000000, 32'd31,       32'hFFFFFFFF);
    op("sra_pos",    4'b1101, 32'h40000000, 32'd1,        32'h20000000);
    op("sra_0",      4'b1101, 32'h80000001, 32'd0,        32'h80000001);
    // Compare
    op("slt_neg",    4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    op("slt_negneg", 4'b0010, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001);
    op("slt_eq",     4'b0010, 32'h12345678, 32'h12345678, 32'h00000000);
    op("slt_posneg", 4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000);
    op("sltu_lt",    4'b0011, 32'h7FFFFFFF, 32'h80000000, 32'h00000001);
    op("sltu_gt",    4'b0011, 32'h80000000, 32'h7FFFFFFF, 32'h00000000);
    // LUI and illegal codes
    op("lui",        4'b1001, 32'h12345678, 32'h87654321, 32'h12345678);
    op("ill_1111",   4'b1111, 32'h12345678, 32'h87654321, 32'hDEADDEAD);
    op("ill_1010",   4'b1010, 32'h00000001, 32'h00000002, 32'hDEADDEAD);
    op("ill_1100",   4'b1100, 32'h00000001, 32'h00000002, 32'hDEADDEAD);
`ifdef OTTER_ALU_FLAGS_EN
    func = 4'b1111; #1;
    check("flag_illegal", {31'b0, illegal}, 32'h1);
    op("add_zero", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0);
    check("flag_zero", {31'b0, zero}, 32'h1);
    check("flag_legal", {31'b0, illegal}, 32'h0);
`endif

    // Register stage: release reset between edges, then capture ADD 2+3
    @(negedge clk);
    rst_n    = 1'b1;
    func     = 4'b0000;
    src_a    = 32'd2;
    src_b    = 32'd3;
    valid_in = 1'b1;
    @(posedge clk); #1;
    check("reg_capture", result_q, 32'd5);
    check("reg_valid1", {31'b0, valid_q}, 32'h1);
`ifdef OTTER_ALU_FLAGS_EN
    check("reg_zero_q", {31'b0, zero_q}, 32'h0);
`endif

    @(negedge clk);
    valid_in = 1'b0;
    src_a    = 32'd7;
    src_b    = 32'd9;
    @(posedge clk); #1;
    check("reg_hold", result_q, 32'd5);
    check("reg_valid0", {31'b0, valid_q}, 32'h0);

    // Asynchronous reset between edges, with a capture pending on the next edge
    valid_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr", result_q, 32'h0);
    @(posedge clk); #1;
    check("async_discard", result_q, 32'h0);
    check("async_valid", {31'b0, valid_q}, 32'h0);

    // Recovery after reset
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("recover", result_q, 32'd16);
    check("recover_valid", {31'b0, valid_q}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
